// File: rtl/sram_access_controller_if.sv
// MEM-stage request bus plus the 16-bit external SRAM pins seen by the
// access controller. "master" is the pipeline/board side, "slave" the controller.
interface sram_access_controller_if #(
  parameter int ADDR_W = 18
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       address;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_in;
  logic              sram_we_n;

  modport master (
    output mem_read, mem_write, address, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  mem_read, mem_write, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_access_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases with
// WAIT_CYCLES wait states each, freezing the pipeline via ready meanwhile.
module sram_access_controller #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  sram_access_controller_if.slave       bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              op_write_reg, op_write_next;
  logic [ADDR_W-2:0] word_addr_reg, word_addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [15:0]       rd_lo_reg, rd_lo_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
  logic [15:0]       dq_out_reg, dq_out_next;
  logic              dq_oe_reg, dq_oe_next;
  logic              we_n_reg, we_n_next;
  logic              ready;

  logic [31:0] eff;
  logic        request;
  logic        phase_last;
  logic        unused_eff_bits;

  // No access may start while reset is held, so ready stays high then too.
  assign request    = rst & (bus.mem_read | bus.mem_write);
  assign eff        = bus.address - 32'(BASE_ADDR);
  assign phase_last = (cnt_reg == CNT_LAST);
  assign unused_eff_bits = ^{eff[31:ADDR_W+1], eff[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_write_reg  <= 1'b0;
      word_addr_reg <= '0;
      wdata_reg     <= '0;
      rd_lo_reg     <= '0;
      rdata_reg     <= '0;
      sram_addr_reg <= '0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      we_n_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_write_reg  <= op_write_next;
      word_addr_reg <= word_addr_next;
      wdata_reg     <= wdata_next;
      rd_lo_reg     <= rd_lo_next;
      rdata_reg     <= rdata_next;
      sram_addr_reg <= sram_addr_next;
      dq_out_reg    <= dq_out_next;
      dq_oe_reg     <= dq_oe_next;
      we_n_reg      <= we_n_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_write_next  = op_write_reg;
    word_addr_next = word_addr_reg;
    wdata_next     = wdata_reg;
    rd_lo_next     = rd_lo_reg;
    rdata_next     = rdata_reg;
    sram_addr_next = sram_addr_reg;
    dq_out_next    = '0;
    dq_oe_next     = 1'b0;
    we_n_next      = 1'b1;
    ready          = 1'b0;

    case (state_reg)
      IDLE: begin
        ready = ~request;
        if (request) begin
          op_write_next  = bus.mem_write;
          word_addr_next = eff[ADDR_W:2];
          wdata_next     = bus.wdata;
          cnt_next       = '0;
          state_next     = LO;
        end
      end
      LO: begin
        if (phase_last) begin
          if (!op_write_reg) rd_lo_next = bus.sram_dq_in;
          cnt_next   = '0;
          state_next = HI;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HI: begin
        if (phase_last) begin
          // rdata changes only as a whole word, so it stays stable until the load ends.
          if (!op_write_reg) rdata_next = {bus.sram_dq_in, rd_lo_reg};
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Pin registers are loaded from the upcoming state so they line up with it.
    if (state_next == LO || state_next == HI) begin
      sram_addr_next = {word_addr_next, (state_next == HI)};
      dq_oe_next     = op_write_next;
      we_n_next      = ~op_write_next;
      if (op_write_next)
        dq_out_next = (state_next == HI) ? wdata_next[31:16] : wdata_next[15:0];
    end
  end

  assign bus.rdata       = rdata_reg;
  assign bus.ready       = ready;
  assign bus.sram_addr   = sram_addr_reg;
  assign bus.sram_dq_out = dq_out_reg;
  assign bus.sram_dq_oe  = dq_oe_reg;
  assign bus.sram_we_n   = we_n_reg;

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller: vector table of single accesses
// plus hand sequences for reset, back-to-back strobes and reset mid-access.
module tb_sram_access_controller;

  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_access_controller_if #(.ADDR_W(ADDR_W)) bus ();

  sram_access_controller #(
    .ADDR_W(ADDR_W), .WAIT_CYCLES(2), .BASE_ADDR(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Asynchronous-read SRAM model for the locations the loads touch.
  always_comb begin
    case (bus.sram_addr)
      18'h00002: bus.sram_dq_in = 16'hBEEF;
      18'h00003: bus.sram_dq_in = 16'hCAFE;
      18'h3FE00: bus.sram_dq_in = 16'h1111;
      18'h3FE01: bus.sram_dq_in = 16'h2222;
      default:   bus.sram_dq_in = 16'h0F0F;
    endcase
  end

  int we_low_cycles = 0;
  always @(negedge clk) if (bus.sram_we_n === 1'b0) we_low_cycles++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        exp_write;
    logic [17:0] exp_lo;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int idx, input vec_t v);
    int we_start;
    @(posedge clk); #1;
    bus.mem_read = v.rd; bus.mem_write = v.wr;
    bus.address = v.address; bus.wdata = v.wdata;
    we_start = we_low_cycles;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (c == 0) begin
        check($sformatf("v%0d c0 ready", idx), 32'(bus.ready), 32'd0);
        check($sformatf("v%0d c0 we_n", idx), 32'(bus.sram_we_n), 32'd1);
      end else if (c <= 4) begin
        check($sformatf("v%0d c%0d ready", idx, c), 32'(bus.ready), 32'd0);
        check($sformatf("v%0d c%0d addr", idx, c), 32'(bus.sram_addr),
              32'(v.exp_lo + ((c >= 3) ? 18'd1 : 18'd0)));
        check($sformatf("v%0d c%0d we_n", idx, c), 32'(bus.sram_we_n), 32'(!v.exp_write));
        check($sformatf("v%0d c%0d oe", idx, c), 32'(bus.sram_dq_oe), 32'(v.exp_write));
        if (v.exp_write)
          check($sformatf("v%0d c%0d dq", idx, c), 32'(bus.sram_dq_out),
                32'((c >= 3) ? v.wdata[31:16] : v.wdata[15:0]));
      end else begin
        check($sformatf("v%0d done ready", idx), 32'(bus.ready), 32'd1);
        check($sformatf("v%0d done we_n", idx), 32'(bus.sram_we_n), 32'd1);
        check($sformatf("v%0d done oe", idx), 32'(bus.sram_dq_oe), 32'd0);
        check($sformatf("v%0d done rdata", idx), bus.rdata, v.exp_rdata);
        check($sformatf("v%0d write cycles", idx), 32'(we_low_cycles - we_start),
              v.exp_write ? 32'd4 : 32'd0);
      end
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle ready", idx), 32'(bus.ready), 32'd1);
    $display("vector %0d: rd=%0b wr=%0b addr=%h rdata=%h", idx, v.rd, v.wr, v.address, bus.rdata);
  endtask

  initial begin
    int we_start;
    int budget;

    //                rd    wr    address       wdata          wr?   lo         rdata
    vecs[0] = '{1'b0, 1'b1, 32'd1024,     32'h12345678, 1'b1, 18'h00000, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1028,     32'h0,        1'b0, 18'h00002, 32'hCAFEBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd0,        32'h0,        1'b0, 18'h3FE00, 32'h22221111};
    vecs[3] = '{1'b1, 1'b0, 32'd1031,     32'h0,        1'b0, 18'h00002, 32'hCAFEBEEF};
    vecs[4] = '{1'b1, 1'b1, 32'd1032,     32'hA5A55A5A, 1'b1, 18'h00004, 32'hCAFEBEEF};

    // Reset held with a pending store: nothing must reach the SRAM.
    bus.mem_read = 1'b0; bus.mem_write = 1'b1;
    bus.address = 32'd1024; bus.wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rst rdata", bus.rdata, 32'd0);
    check("rst addr", 32'(bus.sram_addr), 32'd0);
    check("rst write cycles", 32'(we_low_cycles), 32'd0);
    $display("reset: ready=%0b we_n=%0b rdata=%h", bus.ready, bus.sram_we_n, bus.rdata);
    bus.mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Store held through DONE: one write, then a fresh access from IDLE.
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b1;
    bus.address = 32'd1040; bus.wdata = 32'h0BADF00D;
    we_start = we_low_cycles;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("b2b done ready", 32'(bus.ready), 32'd1);
    check("b2b first write cycles", 32'(we_low_cycles - we_start), 32'd4);
    @(negedge clk);
    check("b2b idle ready", 32'(bus.ready), 32'd0);
    check("b2b idle we_n", 32'(bus.sram_we_n), 32'd1);
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("b2b second lo we_n", 32'(bus.sram_we_n), 32'd0);
    check("b2b second lo addr", 32'(bus.sram_addr), 32'h8);
    budget = 10;
    while (bus.ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("b2b second completes", 32'(budget > 0), 32'd1);
    check("b2b total write cycles", 32'(we_low_cycles - we_start), 32'd8);
    $display("back-to-back: write cycles=%0d", we_low_cycles - we_start);

    // Reset taken during the HI phase of a store abandons it.
    @(posedge clk); #1;
    bus.mem_write = 1'b1; bus.address = 32'd1024; bus.wdata = 32'hFFFF0000;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("mid hi we_n", 32'(bus.sram_we_n), 32'd0);
    check("mid hi addr", 32'(bus.sram_addr), 32'h1);
    rst = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid rst we_n", 32'(bus.sram_we_n), 32'd1);
    check("mid rst oe", 32'(bus.sram_dq_oe), 32'd0);
    check("mid rst addr", 32'(bus.sram_addr), 32'd0);
    check("mid rst rdata", bus.rdata, 32'd0);
    rst = 1'b1;
    we_start = we_low_cycles;
    repeat (3) begin
      @(negedge clk);
      check("post rst ready", 32'(bus.ready), 32'd1);
    end
    check("post rst no write", 32'(we_low_cycles - we_start), 32'd0);
    $display("reset mid-access: ready=%0b we_n=%0b", bus.ready, bus.sram_we_n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
